// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential shift-add IEEE-754 single-precision multiplier, truncating
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ans
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [4:0]          cnt;
  logic                sign;
  logic [7:0]          ea;
  logic [7:0]          eb;
  logic [47:0]         mcand;
  logic [23:0]         mplier;
  logic [47:0]         prod;
  logic signed [9:0]   e;
  logic [22:0]         mant;
  logic [31:0]         ans_next;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL:  if (cnt == 5'd23) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Normalise the finished product and apply zero/underflow/overflow rules.
  always_comb begin
    e        = '0;
    mant     = '0;
    ans_next = '0;
    if (prod[47]) begin
      mant = prod[46:24];
      e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
    end else begin
      mant = prod[45:23];
      e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end
    if (ea == 8'd0 || eb == 8'd0) ans_next = {sign, 31'b0};
    else if (e <= 10'sd0)         ans_next = {sign, 31'b0};
    else if (e >= 10'sd255)       ans_next = {sign, 8'hFF, 23'b0};
    else                          ans_next = {sign, e[7:0], mant};
  end

  // Operand capture, one shift-add step per MUL cycle (multiplier LSB first), result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      ans    <= '0;
      sign   <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign   <= a[31] ^ b[31];
            ea     <= a[30:23];
            eb     <= b[30:23];
            mcand  <= {24'b0, 1'b1, a[22:0]};
            mplier <= {1'b1, b[22:0]};
            prod   <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        NORM: ans <= ans_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking bench for fp_mul_seq
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ans;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex;
    int          ey;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    p  = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
    if (ex == 0 || ey == 0) return {s, 31'b0};
    if (p[47]) begin
      m = p[46:24];
      e = ex + ey - 126;
    end else begin
      m = p[45:23];
      e = ex + ey - 127;
    end
    if (e <= 0)   return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    check32("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(exp);
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic collect(input string name, input bit check_lat);
    int          lat;
    logic [31:0] exp;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check32({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_scoreboard: got result with empty queue expected pending entry", name);
      exp = 32'h0;
    end else begin
      exp = sb.pop_front();
    end
    check32(name, ans, exp);
    if (check_lat) check32({name, "_latency"}, lat, 32'd25);
    tick();
    if (check_lat) begin
      check32({name, "_valid_one_cycle"}, {31'b0, out_valid}, 32'd0);
      check32({name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] x;
    logic [31:0] y;
    int          w;

    vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
    vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[2] = '{32'hBF800000, 32'h40800000, 32'hC0800000};
    vecs[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[4] = '{32'h00800000, 32'h00800000, 32'h00000000};
    vecs[5] = '{32'h00000000, 32'hC0000000, 32'h80000000};
    vecs[6] = '{32'hC0000000, 32'hC0000000, 32'h40800000};
    vecs[7] = '{32'h7F800000, 32'h3F000000, 32'h7F000000};
    vecs[8] = '{32'h00800000, 32'h3F800000, 32'h00800000};
    vecs[9] = '{32'h00800000, 32'h3F000000, 32'h00000000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check32("reset_ans", ans, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].exp);
      collect($sformatf("vec%0d", i), i == 0);
    end

    // Backpressure: result must hold while out_ready is low, input pulses ignored.
    out_ready = 1'b0;
    drive_op(32'h3FC00000, 32'h40000000, 32'h40400000);
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    check32("bp_out_valid", {31'b0, out_valid}, 32'd1);
    held = ans;
    check32("bp_result", ans, sb.size() != 0 ? sb.pop_front() : 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a        = $urandom;
      b        = $urandom;
      tick();
      check32("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check32("bp_hold_ans", ans, held);
      check32("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check32("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check32("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check32("bp_ans_retained", ans, held);
    tick();
    check32("bp_no_queued_op", {31'b0, in_ready}, 32'd1);

    // Reset beats a same-cycle input handshake.
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;
    check32("rst_prio_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of MUL aborts the operation.
    drive_op(32'h40000000, 32'h40400000, 32'h40C00000);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check32("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check32("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check32("abort_ans", ans, 32'h0);
    w = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) w++;
    end
    check32("abort_no_output", w, 32'd0);
    drive_op(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    collect("after_abort", 1'b1);

    for (int i = 0; i < 2000; i++) begin
      x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      y = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      drive_op(x, y, ref_mul(x, y));
      collect("rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
